// File: rtl/matriz_pkg.sv
// matriz_pkg: shared constants for the sequential matrix multiplier.
//   OP_MUL / OP_HAD : op codes for matrix and element-wise product
//   state_e         : controller states IDLE / CALC / DONE
//   *_DEF           : default N_MAX, W and ACC_W
package matriz_pkg;
    localparam int N_MAX_DEF = 5;
    localparam int W_DEF     = 8;
    localparam int ACC_W_DEF = 2 * W_DEF + 4;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_HAD = 3'b011;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/mac_sat.sv
// mac_sat: signed multiply, accumulate-or-bypass, saturate to W bits.
//   a_i, b_i  : signed W-bit operands
//   acc_i     : running accumulator
//   accum_i   : 1 = add product to acc_i, 0 = product alone
//   sum_o     : full-precision sum (never clipped)
//   res_o     : sum_o saturated to W bits
//   clip_o    : res_o differs from sum_o
module mac_sat #(
    parameter int W     = 8,
    parameter int ACC_W = 20
) (
    input  logic signed [W-1:0]     a_i,
    input  logic signed [W-1:0]     b_i,
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic                    accum_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic signed [W-1:0]     res_o,
    output logic                    clip_o
);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_sel;
    logic                    hi, lo;
    always_comb begin
        prod    = a_i * b_i;
        acc_sel = accum_i ? acc_i : '0;
        sum_o   = acc_sel + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
        hi      = sum_o > MAXV;
        lo      = sum_o < MINV;
        clip_o  = hi | lo;
        res_o   = hi ? MAXV[W-1:0] : lo ? MINV[W-1:0] : sum_o[W-1:0];
    end
endmodule

// File: rtl/matriz_mult_seq.sv
// matriz_mult_seq: sequential signed matrix / element-wise multiplier, one MAC per clock.
//   clk, rst     : clock, synchronous active-high reset
//   start, op    : request and operation (OP_MUL / OP_HAD), sampled only in IDLE
//   dim          : active size d, 0 or >N_MAX means N_MAX
//   a_in, b_in   : packed operands, element (i,j) at [(N_MAX*i+j)*W +: W]
//   p_out        : saturated result, same packing, valid from done
//   busy, done   : computing / one-cycle completion pulse
//   sat          : some result element of the last operation was clipped
module matriz_mult_seq
    import matriz_pkg::*;
#(
    parameter int N_MAX = N_MAX_DEF,
    parameter int W     = W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [2:0]               dim,
    input  logic [N_MAX*N_MAX*W-1:0] a_in,
    input  logic [N_MAX*N_MAX*W-1:0] b_in,
    output logic [N_MAX*N_MAX*W-1:0] p_out,
    output logic                     busy,
    output logic                     done,
    output logic                     sat
);
    localparam int PW = N_MAX * N_MAX * W;
    localparam int IW = $clog2(N_MAX * N_MAX);
    localparam logic [2:0] NM = 3'(N_MAX);

    state_e                  state_q, state_d;
    logic [PW-1:0]           a_q, a_d, b_q, b_d, p_q, p_d;
    logic                    had_q, had_d, sat_q, sat_d;
    logic [2:0]              d_q, d_d, i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic signed [W-1:0]     opa, opb, res;
    logic [IW-1:0]           ia, ib, ip;
    logic                    accept, last_k, last_j, last_i, clip;

    // Element-wise mode reuses the matrix datapath with k pinned out:
    // A and B are both indexed by (i,j) and every edge writes a result.
    always_comb begin
        ia  = IW'(i_q) * IW'(N_MAX) + IW'(had_q ? j_q : k_q);
        ib  = IW'(had_q ? i_q : k_q) * IW'(N_MAX) + IW'(j_q);
        ip  = IW'(i_q) * IW'(N_MAX) + IW'(j_q);
        opa = a_q[ia*W +: W];
        opb = b_q[ib*W +: W];
    end

    mac_sat #(.W(W), .ACC_W(ACC_W)) u_mac (
        .a_i    (opa),
        .b_i    (opb),
        .acc_i  (acc_q),
        .accum_i(!had_q),
        .sum_o  (sum),
        .res_o  (res),
        .clip_o (clip)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        had_d   = had_q;
        sat_d   = sat_q;
        d_d     = d_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        accept  = state_q == IDLE && start && (op == OP_MUL || op == OP_HAD);
        last_k  = had_q || k_q == d_q - 3'd1;
        last_j  = j_q == d_q - 3'd1;
        last_i  = i_q == d_q - 3'd1;
        if (accept) begin
            state_d = CALC;
            a_d     = a_in;
            b_d     = b_in;
            had_d   = op == OP_HAD;
            d_d     = (dim == 3'd0 || dim > NM) ? NM : dim;
            p_d     = '0;
            sat_d   = 1'b0;
            acc_d   = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
        end else if (state_q == CALC) begin
            acc_d = last_k ? '0 : sum;
            k_d   = last_k ? 3'd0 : k_q + 3'd1;
            if (last_k) begin
                p_d[ip*W +: W] = res;
                sat_d          = sat_q | clip;
                j_d            = last_j ? 3'd0 : j_q + 3'd1;
                i_d            = last_j ? i_q + 3'd1 : i_q;
                state_d        = (last_j && last_i) ? DONE : CALC;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            had_q   <= 1'b0;
            sat_q   <= 1'b0;
            d_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            had_q   <= had_d;
            sat_q   <= sat_d;
            d_q     <= d_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    assign p_out = p_q;
    assign busy  = state_q == CALC;
    assign done  = state_q == DONE;
    assign sat   = sat_q;
endmodule

// File: tb/tb_matriz_mult_seq.sv
// tb_matriz_mult_seq: scoreboard bench for matriz_mult_seq with a plain-arithmetic reference model.
module tb_matriz_mult_seq;
    import matriz_pkg::*;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int PW = N * N * W;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0]    op = 3'd0, dim = 3'd0;
    logic [PW-1:0] a_in = '0, b_in = '0;
    logic [PW-1:0] p_out;
    logic          busy, done, sat;

    matriz_mult_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .dim  (dim),
        .a_in (a_in),
        .b_in (b_in),
        .p_out(p_out),
        .busy (busy),
        .done (done),
        .sat  (sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0, fails = 0;

    typedef struct {
        logic [PW-1:0] p;
        logic          s;
        int            t0;
        int            lat;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int el(input logic [PW-1:0] m, input int i, input int j);
        logic signed [W-1:0] v;
        v = m[(N*i+j)*W +: W];
        return int'(v);
    endfunction

    function automatic logic [PW-1:0] ref_model(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                                input bit had, input int d, output logic s);
        logic [PW-1:0] p;
        int acc;
        p = '0;
        s = 1'b0;
        for (int i = 0; i < d; i++)
            for (int j = 0; j < d; j++) begin
                acc = 0;
                if (had) acc = el(a, i, j) * el(b, i, j);
                else for (int k = 0; k < d; k++) acc += el(a, i, k) * el(b, k, j);
                if (acc > 127) begin acc = 127; s = 1'b1; end
                else if (acc < -128) begin acc = -128; s = 1'b1; end
                p[(N*i+j)*W +: W] = W'(acc);
            end
        return p;
    endfunction

    function automatic logic [PW-1:0] rnd_mat(input int mode);
        logic [PW-1:0] m;
        logic [7:0] ext [4];
        ext[0] = 8'h7f; ext[1] = 8'h80; ext[2] = 8'h81; ext[3] = 8'h01;
        for (int e = 0; e < N*N; e++)
            m[e*W +: W] = mode == 0 ? 8'($urandom_range(255)) : ext[$urandom_range(3)];
        return m;
    endfunction

    function automatic logic [PW-1:0] fill(input logic [7:0] v);
        logic [PW-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*W +: W] = v;
        return m;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy || done) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy=%0b done=%0b still set after %0d cycles, required idle", busy, done, n);
        end
    endtask

    task automatic issue(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [2:0] o,
                         input logic [2:0] d, input bit wait_first);
        exp_t e;
        logic s;
        int dd;
        bit ok;
        if (wait_first) wait_idle();
        ok   = !busy && !done && (o == OP_MUL || o == OP_HAD);
        a_in = a;
        b_in = b;
        op   = o;
        dim  = d;
        start = 1'b1;
        if (ok) begin
            dd    = (d == 0 || d > 5) ? 5 : int'(d);
            e.p   = ref_model(a, b, o == OP_HAD, dd, s);
            e.s   = s;
            e.t0  = cyc + 1;
            e.lat = o == OP_HAD ? dd * dd : dd * dd * dd;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (ok) check("busy_after_accept", PW'(busy), PW'(1));
        else if (o != OP_MUL && o != OP_HAD) check("busy_bad_op", PW'(busy), PW'(0));
        a_in = rnd_mat(0);
        b_in = rnd_mat(0);
        op   = 3'd0;
    endtask

    bit prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending operation", cyc);
            end else begin
                e = sb.pop_front();
                check("p_out", p_out, e.p);
                check("sat", PW'(sat), PW'(e.s));
                check("latency", PW'(cyc - e.t0), PW'(e.lat));
                check("busy_with_done", PW'(busy), PW'(0));
                check("done_width", PW'(prev_done), PW'(0));
            end
        end
        prev_done = done;
    end

    initial begin
        logic [PW-1:0] a, b;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_p_out", p_out, '0);
        check("rst_busy", PW'(busy), PW'(0));
        check("rst_done", PW'(done), PW'(0));
        check("rst_sat", PW'(sat), PW'(0));

        a = '0;
        for (int i = 0; i < N; i++) a[(N*i+i)*W +: W] = 8'd1;
        for (int e = 0; e < N*N; e++) b[e*W +: W] = 8'(e + 1);
        issue(a, b, OP_MUL, 3'd5, 1);

        issue(fill(8'd127), fill(8'd127), OP_MUL, 3'd5, 1);

        a = '0;
        a[0 +: 40] = {8'd0, 8'h81, 8'h81, 8'd127, 8'd127};
        issue(a, fill(8'd1), OP_MUL, 3'd5, 1);
        issue(fill(8'h80), fill(8'd1), OP_MUL, 3'd5, 1);

        a = rnd_mat(0);
        b = rnd_mat(0);
        a[0*W +: W] = 8'd2;  a[1*W +: W] = 8'hfd; a[5*W +: W] = 8'd4;   a[6*W +: W] = 8'd5;
        b[0*W +: W] = 8'd3;  b[1*W +: W] = 8'd3;  b[5*W +: W] = 8'hd8; b[6*W +: W] = 8'd30;
        issue(a, b, OP_HAD, 3'd2, 1);

        issue(rnd_mat(0), rnd_mat(0), 3'b000, 3'd5, 1);
        issue(rnd_mat(0), rnd_mat(0), 3'b111, 3'd3, 1);
        repeat (4) @(posedge clk);
        #1 check("bad_op_idle", PW'(busy), PW'(0));

        issue(rnd_mat(0), rnd_mat(0), OP_MUL, 3'd3, 1);
        repeat (5) @(posedge clk);
        #1 issue(rnd_mat(1), rnd_mat(1), OP_HAD, 3'd2, 0);

        issue(rnd_mat(0), rnd_mat(0), OP_MUL, 3'd0, 1);
        issue(rnd_mat(1), rnd_mat(1), OP_HAD, 3'd7, 1);

        issue(rnd_mat(0), rnd_mat(0), OP_MUL, 3'd5, 1);
        repeat (49) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        check("abort_p_out", p_out, '0);
        check("abort_busy", PW'(busy), PW'(0));
        check("abort_done", PW'(done), PW'(0));
        check("abort_sat", PW'(sat), PW'(0));
        issue(rnd_mat(1), rnd_mat(0), OP_MUL, 3'd4, 1);

        for (int t = 0; t < 20; t++)
            issue(rnd_mat(t % 3 == 0 ? 1 : 0), rnd_mat(t % 2), $urandom_range(1) ? OP_MUL : OP_HAD,
                  3'($urandom_range(7)), 1);

        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d operations still pending, required 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matriz_mult_seq.md
# matriz_mult_seq

Sequential, parametrised signed matrix multiplier for the ALU datapath. It computes either the matrix product or the element-wise product of two square int matrices of runtime-selectable size up to N_MAX×N_MAX. It uses one multiply-accumulate per clock and saturates the final sums. It replaces the single-cycle fixed 5×5 multiplier with a start/busy/done handshake, a sticky saturation flag and full-precision accumulation.

## Interface
- N_MAX, 5, maximum matrix dimension
- W, 8, element width, signed two's complement
- ACC_W, 2*W+4, accumulator width; must hold N_MAX products without wrap
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  3'b010 = matrix product, 3'b011 = element-wise product; any other value makes start ignored
- dim  in  3  active size d; 0 or >N_MAX is treated as N_MAX
- a_in  in  N_MAX*N_MAX*W  matrix A, element (i,j) at [(N_MAX*i+j)*W +: W]
- b_in  in  N_MAX*N_MAX*W  matrix B, same packing
- p_out  out  N_MAX*N_MAX*W  result, same packing
- busy  out  1  high while computing
- done  out  1  one-cycle completion pulse
- sat  out  1  sticky: at least one result element clipped in the last operation

## Operation
- States:
  - IDLE → CALC on an edge with start=1 and a valid op.
  - CALC → DONE after the last element is written.
  - DONE → IDLE unconditionally.
- Accept edge:
  - Captures a_in, b_in, op and the clamped d into internal registers. Inputs may change afterwards.
  - Clears p_out, sat, accumulator and counters i, j, k.
- Matrix mode (CALC):
  - Each edge does acc += A[i][k]*B[k][j], a full-precision signed product into ACC_W bits.
  - When k=d-1, the saturated acc+product is written to P[i][j], acc is cleared, k wraps to 0, and j advances. When j=d-1, j wraps and i advances.
- Element-wise mode (CALC): each edge writes sat(A[i][j]*B[i][j]) to P[i][j]. k is unused.
- Saturation:
  - Applies to the final value only; intermediate sums are never clipped.
  - Values >2^(W-1)-1 become 2^(W-1)-1. Values <-2^(W-1) become -2^(W-1).
  - Any clip sets sat.
- Elements outside the d×d region of p_out are 0.
- start in CALC or DONE is ignored (no queueing).
- Reset, including mid-operation:
  - Returns to IDLE and aborts the operation.
  - p_out=0, busy=0, done=0, sat=0, accumulator and counters cleared.
  - No done pulse for the aborted operation.

## Timing
- Reset values: p_out=0, busy=0, done=0, sat=0, state IDLE.
- Start accepted at edge t: busy=1 from t.
- Last MAC edge is t+L:
  - L = d³ for matrix mode, L = d² for element-wise mode.
  - At edge t+L: the last element is written, busy=0, done=1.
  - At edge t+L+1: done=0.
- Examples: d=5 matrix, done high 125 cycles after accept; d=5 element-wise, 25 cycles.
- p_out during CALC is partial and undefined for consumers. It is valid from the done cycle and held until the next accepted start or reset.
- sat is valid with done and held likewise.
- start in the done cycle is ignored; a new start is accepted from the next IDLE cycle.

## Structure
- Package matriz_pkg holds:
  - op constants OP_MUL=3'b010 and OP_HAD=3'b011
  - state encoding IDLE/CALC/DONE
  - defaults for N_MAX, W and ACC_W
- Sub-module mac_sat: signed multiply, accumulate-or-bypass select, and saturation to W bits with a clip flag. It is parametrised by W and ACC_W.
- Top level holds the FSM, the i/j/k counters with d-wrap, and the operand and result registers.

## Test plan
- A=identity, B=elements 1..25, d=5, op=010: P=B; done after exactly 125 cycles, one cycle wide; sat=0; busy falls with done.
- A=all 127, B=all 127, d=5, op=010: every element 127 (true sum 80645); sat=1.
- Row 0 of A=[127,127,-127,-127,0], B all 1, d=5, op=010: P[0][j]=0, sat=0. Proves no intermediate clipping. A=all -128, B all 1: every element -128, sat=1.
- d=2, op=011, A=[[2,-3],[4,5]], B=[[3,3],[-40,30]]: P=[[6,-9],[-128,127]]; sat=1; done after 4 cycles; all elements outside 2×2 are 0.
- Handshake and boundaries:
  - start with op=000: busy stays 0.
  - Second start during CALC: ignored, original result intact.
  - dim=0: behaves as d=5.
  - rst at cycle 50 of a d=5 matrix operation: busy=0, p_out=0, no done; a following start completes normally.
